// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and sizing helpers for the parametrised FIFO
//
// Purpose: default parameter values plus pointer-width and depth derivation
//          used by fifo_param and fifo_mem.
// Ports:   none (package).
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_FWFT       = 0;

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - flop-array storage with one write port and one async read port
//
// Purpose: FIFO storage; contents are deliberately not reset.
// Ports:   clk   - clock, write on rising edge
//          we    - write enable
//          waddr - write address
//          wdata - write data
//          raddr - read address
//          rdata - combinational read data at raddr
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised single-clock FIFO with count, thresholds and sticky errors
//
// Purpose: synchronous FIFO with occupancy count, programmable almost-full /
//          almost-empty thresholds, sticky overflow/underflow, synchronous
//          flush and an optional first-word-fall-through read mode.
// Ports:   clk, rst_n      - clock, async active-low reset
//          wr, rd          - write / read requests
//          data_in         - write data
//          flush           - synchronous clear of contents and error flags
//          clr_err         - clears sticky error flags
//          af_level        - almost-full threshold (count >= af_level)
//          ae_level        - almost-empty threshold (count <= ae_level)
//          data_out        - read data (registered, or head word when FWFT=1)
//          fifo_count      - occupancy 0..DEPTH
//          fifo_full/empty - occupancy flags
//          almost_full/almost_empty - threshold flags
//          fifo_overflow/fifo_underflow - sticky rejected-access flags
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [ADDR_WIDTH:0]   af_level,
  input  logic [ADDR_WIDTH:0]   ae_level,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] ONE = 1;

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         count;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rdata;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PW-1] != rptr[PW-1]) &&
                      (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // A write into a full FIFO still lands when a read frees a slot this cycle.
  assign rd_ok = rd & ~fifo_empty;
  assign wr_ok = wr & (~fifo_full | rd_ok);

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok & ~flush),
    .waddr(wptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rptr[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + ONE;
      if (rd_ok) rptr <= rptr + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: flush clears outright; otherwise a new error beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else if (flush) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr & ~wr_ok)  fifo_overflow <= 1'b1;
      else if (clr_err) fifo_overflow <= 1'b0;
      if (rd & ~rd_ok)  fifo_underflow <= 1'b1;
      else if (clr_err) fifo_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = rdata;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (flush) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= rdata;
        end
      end
      assign data_out = dout_q;
    end
  endgenerate

  assign fifo_count   = count;
  assign almost_full  = (count >= af_level);
  assign almost_empty = (count <= ae_level);

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param (registered and FWFT instances)
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [4:0] af_level = 5'd16;
  logic [4:0] ae_level = 5'd0;

  logic [7:0] dout0, dout1;
  logic [4:0] cnt0, cnt1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .flush(flush), .clr_err(clr_err), .af_level(af_level), .ae_level(ae_level),
    .data_out(dout0), .fifo_count(cnt0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fifo_overflow(ovf0), .fifo_underflow(unf0)
  );

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .flush(flush), .clr_err(clr_err), .af_level(af_level), .ae_level(ae_level),
    .data_out(dout1), .fifo_count(cnt1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fifo_overflow(ovf1), .fifo_underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_count", cnt0, 0);
    check("rst_dout", dout0, 8'h00);
    check("rst_ae", ae0, 1);
    check("rst_af", af0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_unf", unf0, 0);
    af_level = 5'd0;
    #1;
    check("rst_af_lvl0", af0, 1);
    af_level = 5'd16;
    tick();
    rst_n = 1'b1;
    tick();

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data_in = 8'(i);
      tick();
    end
    wr = 1'b0;
    check("fill_full", full0, 1);
    check("fill_count", cnt0, 16);
    check("fill_ovf", ovf0, 0);
    check("fill_af", af0, 1);
    wr = 1'b1; data_in = 8'h99;
    tick();
    wr = 1'b0;
    check("w17_ovf", ovf0, 1);
    check("w17_count", cnt0, 16);

    // drain, checking order and one-cycle latency; FWFT shows head beforehand
    for (int i = 0; i < 16; i++) begin
      check("fwft_head", dout1, 8'(i));
      rd = 1'b1;
      tick();
      check("rd_data", dout0, 8'(i));
    end
    rd = 1'b0;
    check("drain_empty", empty0, 1);
    check("drain_count", cnt0, 0);

    // underflow and clear
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("unf_set", unf0, 1);
    check("unf_count", cnt0, 0);
    check("unf_dout", dout0, 8'h0F);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_unf", unf0, 0);
    check("clr_ovf", ovf0, 0);
    rd = 1'b1; clr_err = 1'b1;
    tick();
    rd = 1'b0; clr_err = 1'b0;
    check("set_wins", unf0, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_unf2", unf0, 0);

    // full FIFO with simultaneous wr/rd, pointers wrap
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data_in = 8'h20 + 8'(i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1; data_in = 8'h30 + 8'(i);
      tick();
      check("rw_data", dout0, (i < 16) ? 8'h20 + 8'(i) : 8'h30 + 8'(i - 16));
      check("rw_count", cnt0, 16);
    end
    wr = 1'b0; rd = 1'b0;
    check("rw_ovf", ovf0, 0);
    for (int i = 4; i < 20; i++) begin
      rd = 1'b1;
      tick();
      check("rw_drain", dout0, 8'h30 + 8'(i));
    end
    rd = 1'b0;
    check("rw_empty", empty0, 1);

    // thresholds
    af_level = 5'd12; ae_level = 5'd3;
    #1;
    check("thr_ae0", ae0, 1);
    check("thr_af0", af0, 0);
    for (int k = 1; k <= 10; k++) begin
      wr = 1'b1; data_in = 8'h40 + 8'(k);
      tick();
      check("thr_ae", ae0, (k <= 3) ? 1 : 0);
      check("thr_af", af0, (k >= 12) ? 1 : 0);
    end
    wr = 1'b0;
    af_level = 5'd8;
    #1;
    check("thr_af_live", af0, 1);

    // flush, then FWFT single word
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_count", cnt0, 0);
    check("fl_dout", dout0, 8'h00);
    wr = 1'b1; data_in = 8'hA5;
    tick();
    wr = 1'b0;
    check("fwft_dout", dout1, 8'hA5);
    check("fwft_nempty", empty1, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fwft_empty", empty1, 1);
    check("reg_dout_a5", dout0, 8'hA5);

    // flush with wr at count 9, overflow set
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; data_in = 8'h50 + 8'(i);
      tick();
    end
    wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    check("pre_fl_count", cnt0, 9);
    check("pre_fl_ovf", ovf0, 1);
    flush = 1'b1; wr = 1'b1; data_in = 8'hEE;
    tick();
    flush = 1'b0; wr = 1'b0;
    check("flw_count", cnt0, 0);
    check("flw_empty", empty0, 1);
    check("flw_ovf", ovf0, 0);
    wr = 1'b1; data_in = 8'h11;
    tick();
    wr = 1'b0;
    check("flw_head", dout1, 8'h11);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("flw_data", dout0, 8'h11);

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data_in = 8'h60 + 8'(i);
      tick();
    end
    check("burst_count", cnt0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    wr = 1'b0;
    check("ar_count", cnt0, 0);
    check("ar_empty", empty0, 1);
    check("ar_full", full0, 0);
    check("ar_dout", dout0, 8'h00);
    check("ar_ae", ae0, 1);
    check("ar_ovf", ovf0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the team's 8-bit FIFO. Generalises data width and depth and adds an occupancy count. Adds runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow with clear, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used as the standard single-clock buffer between streaming sub-blocks.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
FWFT, 0, 0 = registered read (data one cycle after rd); 1 = head word visible on data_out while not empty

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr  input  1  write request
rd  input  1  read request
data_in  input  DATA_WIDTH  write data
flush  input  1  synchronous clear of FIFO contents and error flags
clr_err  input  1  clears sticky fifo_overflow/fifo_underflow
af_level  input  ADDR_WIDTH+1  almost-full threshold
ae_level  input  ADDR_WIDTH+1  almost-empty threshold
data_out  output  DATA_WIDTH  read data
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= af_level
almost_empty  output  1  count <= ae_level
fifo_overflow  output  1  sticky: write rejected while full
fifo_underflow  output  1  sticky: read rejected while empty

Behaviour:
- Reset (rst_n low, async): wptr = rptr = 0, count = 0, data_out = 0, both sticky flags 0. After reset: fifo_empty = 1, fifo_full = 0, almost_empty = 1 (for ae_level >= 0), almost_full = 1 only if af_level == 0. Memory array is not reset.
- Pointers are ADDR_WIDTH+1 bits. Address = low ADDR_WIDTH bits. Wrap is natural binary rollover.
- Full: MSBs differ and low bits equal. Empty: pointers equal. fifo_count = wptr - rptr, modulo 2**(ADDR_WIDTH+1), registered.
- Accept rules:
  - rd_ok = rd & ~fifo_empty
  - wr_ok = wr & (~fifo_full | rd_ok); a write to a full FIFO is accepted when a read is accepted in the same cycle.
  - A write to an empty FIFO with rd high: write accepted, read rejected, underflow set.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Mode FWFT=0: on rd_ok, data_out <= mem[rptr] at the next edge (1-cycle latency). Otherwise data_out holds its last value.
- Mode FWFT=1: data_out = mem[rptr] combinationally; rd_ok pops. Value on data_out is don't-care while fifo_empty = 1. Write-to-visible latency is 1 cycle (the word appears after the write edge).
- Sticky flags:
  - fifo_overflow set on wr & ~wr_ok.
  - fifo_underflow set on rd & ~rd_ok.
  - Both held until clr_err or flush. If set and clear occur in the same cycle, set wins.
- flush (synchronous) has priority over wr/rd in the same cycle. It zeroes the pointers and count and clears both sticky flags. Under FWFT=0 it also zeroes data_out. A wr in the flush cycle is dropped.
- almost_full and almost_empty are combinational compares on the registered count. Threshold changes take effect immediately.
- Asserting rst_n mid-operation discards all contents; there is no partial state.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(addr_w) = addr_w+1
  - localparam DEPTH derivation helper
  - default-parameter constants
- One sub-module, fifo_mem: a flop array with one write port and one asynchronous read port, parametrised by DATA_WIDTH/ADDR_WIDTH. Pointer, count, flag and output-register logic live in fifo_param.

Test Plan:
- DATA_WIDTH=8, ADDR_WIDTH=4, FWFT=0: write 0x00..0x0F -> fifo_full=1, count=16. 17th write -> overflow=1, count stays 16. Read 16 -> data_out 0x00..0x0F in order, each one cycle after rd.
- Empty FIFO, rd pulse -> underflow=1, count=0, data_out unchanged. clr_err -> underflow=0. rd and clr_err in the same cycle on empty -> underflow stays 1.
- Full FIFO, wr=rd=1 for 20 cycles with incrementing data -> no overflow, count stays 16, read data continues the sequence, and pointers wrap with no break.
- af_level=12, ae_level=3: fill from 0 -> almost_empty falls when count reaches 4; almost_full rises when count reaches 12. Change af_level to 8 at count 10 -> almost_full=1 the same cycle.
- FWFT=1: single write 0xA5 -> data_out=0xA5 and fifo_empty=0 one cycle after wr. rd -> empty=1 the next cycle.
- Count 9 with sticky overflow set: flush together with wr -> count=0, empty=1, overflow=0, and the written word is discarded. Async rst_n pulse mid-burst -> all outputs return to reset values immediately.
